// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : reg_write_arbiter
//  Purpose  : Shares the register-file write port between pipeline writeback
//             and a FIFO-buffered auxiliary unit, with a starvation stall.
//  Revision : 1.0
// ============================================================================
module reg_write_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_write_en,
    input  logic [ADDR_WIDTH-1:0] pipe_write_addr,
    input  logic [DATA_WIDTH-1:0] pipe_write_data,
    output logic                  stall_req,
    input  logic                  aux_valid,
    input  logic [ADDR_WIDTH-1:0] aux_addr,
    input  logic [DATA_WIDTH-1:0] aux_data,
    output logic                  aux_ready,
    output logic                  rf_write_en,
    output logic [ADDR_WIDTH-1:0] rf_write_addr,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    input  logic [ADDR_WIDTH-1:0] query_addr_1,
    input  logic [ADDR_WIDTH-1:0] query_addr_2,
    output logic                  query_hit_1,
    output logic                  query_hit_2
);

    localparam int c_ptr_w  = $clog2(DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;
    localparam int c_wait_w = $clog2(MAX_WAIT + 1);

    localparam logic [c_cnt_w-1:0]  c_depth    = c_cnt_w'(DEPTH);
    localparam logic [c_wait_w-1:0] c_max_wait = c_wait_w'(MAX_WAIT);
    localparam logic [c_ptr_w-1:0]  c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_wait_w-1:0] c_wait_one = c_wait_w'(1);

    logic [ADDR_WIDTH-1:0] r_addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];
    logic [DEPTH-1:0]      r_valid;
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;
    logic [c_wait_w-1:0]   r_wait_cnt;

    logic                  w_empty;
    logic                  w_stall;
    logic                  w_pipe_live;
    logic                  w_pop;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_push;
    logic [DEPTH-1:0]      w_valid_nxt;
    logic [DEPTH-1:0]      w_match_1;
    logic [DEPTH-1:0]      w_match_2;

    assign w_empty     = (r_count == '0);
    assign w_stall     = (r_wait_cnt == c_max_wait);
    assign w_pipe_live = pipe_write_en && (pipe_write_addr != '0);
    // The head drains on a forced stall or whenever the pipeline leaves the slot idle.
    assign w_pop       = !w_empty && (w_stall || !w_pipe_live);
    assign w_ready     = rst && (r_count != c_depth);
    assign w_accept    = aux_valid && w_ready;
    assign w_push      = w_accept && (aux_addr != '0);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_query
            assign w_match_1[gi] = r_valid[gi] && (r_addr_mem[gi] == query_addr_1);
            assign w_match_2[gi] = r_valid[gi] && (r_addr_mem[gi] == query_addr_2);
        end
    endgenerate

    always_comb begin
        w_valid_nxt = r_valid;
        if (w_pop) begin
            w_valid_nxt[r_rd_ptr] = 1'b0;
        end
        if (w_push) begin
            w_valid_nxt[r_wr_ptr] = 1'b1;
        end
    end

    always_comb begin
        stall_req     = 1'b0;
        aux_ready     = 1'b0;
        rf_write_en   = 1'b0;
        rf_write_addr = '0;
        rf_write_data = '0;
        query_hit_1   = 1'b0;
        query_hit_2   = 1'b0;
        if (rst) begin
            stall_req = w_stall;
            aux_ready = w_ready;
            if (w_pop) begin
                rf_write_en   = 1'b1;
                rf_write_addr = r_addr_mem[r_rd_ptr];
                rf_write_data = r_data_mem[r_rd_ptr];
            end else if (w_pipe_live) begin
                rf_write_en   = 1'b1;
                rf_write_addr = pipe_write_addr;
                rf_write_data = pipe_write_data;
            end
            query_hit_1 = (query_addr_1 != '0) && (|w_match_1);
            query_hit_2 = (query_addr_2 != '0) && (|w_match_2);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
            // Each new head restarts its wait from zero.
            if (w_pop || w_empty) begin
                r_wait_cnt <= '0;
            end else begin
                r_wait_cnt <= r_wait_cnt + c_wait_one;
            end
        end
    end

    // Payload storage needs no reset; r_valid and r_count qualify every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_mem[r_wr_ptr] <= aux_addr;
            r_data_mem[r_wr_ptr] <= aux_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_write_arbiter
//  Purpose  : Directed and randomized bench for reg_write_arbiter against a
//             queue-based reference model.
//  Revision : 1.0
// ============================================================================
module tb_reg_write_arbiter;

    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 4;
    localparam int MAX_WAIT   = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  pipe_write_en;
    logic [ADDR_WIDTH-1:0] pipe_write_addr;
    logic [DATA_WIDTH-1:0] pipe_write_data;
    logic                  stall_req;
    logic                  aux_valid;
    logic [ADDR_WIDTH-1:0] aux_addr;
    logic [DATA_WIDTH-1:0] aux_data;
    logic                  aux_ready;
    logic                  rf_write_en;
    logic [ADDR_WIDTH-1:0] rf_write_addr;
    logic [DATA_WIDTH-1:0] rf_write_data;
    logic [ADDR_WIDTH-1:0] query_addr_1;
    logic [ADDR_WIDTH-1:0] query_addr_2;
    logic                  query_hit_1;
    logic                  query_hit_2;

    reg_write_arbiter #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .MAX_WAIT  (MAX_WAIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pipe_write_en  (pipe_write_en),
        .pipe_write_addr(pipe_write_addr),
        .pipe_write_data(pipe_write_data),
        .stall_req      (stall_req),
        .aux_valid      (aux_valid),
        .aux_addr       (aux_addr),
        .aux_data       (aux_data),
        .aux_ready      (aux_ready),
        .rf_write_en    (rf_write_en),
        .rf_write_addr  (rf_write_addr),
        .rf_write_data  (rf_write_data),
        .query_addr_1   (query_addr_1),
        .query_addr_2   (query_addr_2),
        .query_hit_1    (query_hit_1),
        .query_hit_2    (query_hit_2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } ent_t;

    ent_t q[$];
    int   mwait;
    int   tests_run    = 0;
    int   tests_failed = 0;

    logic                  last_stall;
    logic                  last_ready;
    logic                  last_en;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [DATA_WIDTH-1:0] last_data;
    logic                  last_hit1;
    logic                  last_hit2;
    logic                  exp_stall_prev;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: predict outputs from the queue model, compare mid-cycle,
    // then advance the model at the rising edge.
    task automatic cycle();
        int                    sz;
        bit                    stall_e, pipe_ok, pop, acc, h1, h2, ee;
        logic [ADDR_WIDTH-1:0] ea;
        logic [DATA_WIDTH-1:0] ed;
        @(negedge clk);
        sz      = q.size();
        stall_e = (mwait == MAX_WAIT);
        pipe_ok = pipe_write_en && (pipe_write_addr != 0);
        pop     = (sz > 0) && (stall_e || !pipe_ok);
        ee = 1'b0; ea = '0; ed = '0;
        if (pop) begin
            ee = 1'b1; ea = q[0].addr; ed = q[0].data;
        end else if (pipe_ok) begin
            ee = 1'b1; ea = pipe_write_addr; ed = pipe_write_data;
        end
        h1 = 1'b0; h2 = 1'b0;
        foreach (q[i]) begin
            if (query_addr_1 != 0 && q[i].addr == query_addr_1) h1 = 1'b1;
            if (query_addr_2 != 0 && q[i].addr == query_addr_2) h2 = 1'b1;
        end
        chk("stall_req", stall_req, stall_e);
        chk("aux_ready", aux_ready, sz != DEPTH);
        chk("rf_write_en", rf_write_en, ee);
        chk("rf_write_addr", rf_write_addr, ea);
        chk("rf_write_data", rf_write_data, ed);
        chk("query_hit_1", query_hit_1, h1);
        chk("query_hit_2", query_hit_2, h2);
        last_stall = stall_req; last_ready = aux_ready; last_en = rf_write_en;
        last_addr = rf_write_addr; last_data = rf_write_data;
        last_hit1 = query_hit_1; last_hit2 = query_hit_2;
        exp_stall_prev = stall_e;
        acc = aux_valid && (sz != DEPTH);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (acc && aux_addr != 0) q.push_back('{addr: aux_addr, data: aux_data});
        mwait = (pop || sz == 0) ? 0 : mwait + 1;
        #1;
    endtask

    logic [ADDR_WIDTH-1:0] wr_order[$];
    int pushed;
    bit full_seen, written;

    initial begin
        rst = 1'b0; pipe_write_en = 1'b0; pipe_write_addr = '0; pipe_write_data = '0;
        aux_valid = 1'b0; aux_addr = '0; aux_data = '0;
        query_addr_1 = 5'd3; query_addr_2 = 5'd4;
        mwait = 0; exp_stall_prev = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", stall_req, 0);
        chk("reset_ready", aux_ready, 0);
        chk("reset_en", rf_write_en, 0);
        chk("reset_addr", rf_write_addr, 0);
        chk("reset_data", rf_write_data, 0);
        chk("reset_hit1", query_hit_1, 0);
        rst = 1'b1;
        query_addr_1 = '0; query_addr_2 = '0;
        cycle();

        // Priority: pipeline r1..r4, aux r5 queued behind it
        aux_valid = 1'b1; aux_addr = 5'd5; aux_data = 32'h0000_1234;
        for (int i = 1; i <= 4; i++) begin
            pipe_write_en = 1'b1; pipe_write_addr = 5'(i); pipe_write_data = 32'h100 + i;
            cycle();
            aux_valid = 1'b0;
            chk("prio_pipe_addr", last_addr, i);
        end
        pipe_write_en = 1'b0;
        cycle();
        chk("prio_aux_addr", last_addr, 5);
        chk("prio_aux_data", last_data, 32'h0000_1234);

        // Starvation: busy pipeline, aux r9 accepted at E0
        pipe_write_en = 1'b1; pipe_write_addr = 5'd10; pipe_write_data = 32'hA000;
        aux_valid = 1'b1; aux_addr = 5'd9; aux_data = 32'hCAFE_F00D;
        cycle();
        aux_valid = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            if (!exp_stall_prev) begin
                pipe_write_addr = 5'(10 + k); pipe_write_data = 32'hA000 + k;
            end
            cycle();
            chk("starve_stall", last_stall, k == MAX_WAIT + 1);
            if (k == MAX_WAIT + 1) begin
                chk("starve_head_addr", last_addr, 9);
                chk("starve_head_data", last_data, 32'hCAFE_F00D);
            end
            if (k == MAX_WAIT + 2) chk("starve_held", last_addr, 10 + MAX_WAIT + 1);
        end

        // Full FIFO: five aux results offered back-to-back under a busy pipeline
        pushed = 0; full_seen = 1'b0;
        aux_valid = 1'b1; aux_addr = 5'd20; aux_data = 32'hF0;
        for (int k = 0; k < 70; k++) begin
            if (!exp_stall_prev) begin
                pipe_write_en = (k < 60); pipe_write_addr = 5'(1 + k % 3); pipe_write_data = 32'hB000 + k;
            end
            cycle();
            if (full_seen) begin
                chk("full_ready_low", last_ready, 0);
                full_seen = 1'b0;
            end
            if (last_en && last_addr >= 20) wr_order.push_back(last_addr);
            if (aux_valid && last_ready) begin
                pushed++;
                if (pushed == 4) full_seen = 1'b1;
                if (pushed < 5) begin
                    aux_addr = 5'(20 + pushed); aux_data = 32'hF0 + pushed;
                end else begin
                    aux_valid = 1'b0;
                end
            end
        end
        chk("full_pushed", pushed, 5);
        chk("full_order_len", wr_order.size(), 5);
        foreach (wr_order[i]) chk("full_order", wr_order[i], 20 + i);

        // r0 handling
        pipe_write_en = 1'b1; pipe_write_addr = 5'd2; pipe_write_data = 32'h22;
        aux_valid = 1'b1; aux_addr = 5'd11; aux_data = 32'h0B0B;
        cycle();
        aux_valid = 1'b0;
        pipe_write_addr = 5'd0; pipe_write_data = 32'hFFFF_FFFF;
        cycle();
        chk("r0_pop_en", last_en, 1);
        chk("r0_pop_addr", last_addr, 11);
        pipe_write_en = 1'b0; aux_valid = 1'b1; aux_addr = 5'd0; aux_data = 32'hDEAD;
        query_addr_1 = 5'd0;
        cycle();
        chk("r0_ready", last_ready, 1);
        aux_valid = 1'b0;
        cycle();
        chk("r0_no_write", last_en, 0);
        chk("r0_query", last_hit1, 0);

        // Query: r7 buffered behind a busy pipeline
        pipe_write_en = 1'b1; pipe_write_addr = 5'd1; pipe_write_data = 32'h77;
        aux_valid = 1'b1; aux_addr = 5'd7; aux_data = 32'h7777;
        query_addr_1 = 5'd7; query_addr_2 = 5'd8;
        cycle();
        aux_valid = 1'b0; written = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (!exp_stall_prev) begin
                pipe_write_addr = 5'(1 + k % 3); pipe_write_data = 32'hC000 + k;
            end
            cycle();
            chk("q_hit2", last_hit2, 0);
            if (!written) begin
                chk("q_hit1_pending", last_hit1, 1);
                if (last_en && last_addr == 7) written = 1'b1;
            end else begin
                chk("q_hit1_after", last_hit1, 0);
            end
        end
        chk("q_written", written, 1);

        // Randomized traffic, pipeline honouring the stall contract
        for (int n = 0; n < 300; n++) begin
            if (!exp_stall_prev) begin
                pipe_write_en   = ($urandom_range(0, 3) != 0);
                pipe_write_addr = 5'($urandom_range(0, 7));
                pipe_write_data = $urandom;
            end
            aux_valid    = $urandom_range(0, 1) == 1;
            aux_addr     = 5'($urandom_range(0, 7));
            aux_data     = $urandom;
            query_addr_1 = 5'($urandom_range(0, 7));
            query_addr_2 = 5'($urandom_range(0, 7));
            cycle();
        end

        // Asynchronous reset with three buffered entries
        pipe_write_en = 1'b0; aux_valid = 1'b0;
        repeat (8) cycle();
        pipe_write_en = 1'b1; pipe_write_addr = 5'd1; pipe_write_data = 32'h11;
        for (int i = 0; i < 3; i++) begin
            aux_valid = 1'b1; aux_addr = 5'(12 + i); aux_data = 32'hE0 + i;
            cycle();
        end
        aux_valid = 1'b0; query_addr_1 = 5'd12; query_addr_2 = 5'd14;
        #3;
        rst = 1'b0;
        #1;
        chk("arst_stall", stall_req, 0);
        chk("arst_ready", aux_ready, 0);
        chk("arst_en", rf_write_en, 0);
        chk("arst_addr", rf_write_addr, 0);
        chk("arst_data", rf_write_data, 0);
        chk("arst_hit1", query_hit_1, 0);
        chk("arst_hit2", query_hit_2, 0);
        @(posedge clk);
        #1;
        q.delete(); mwait = 0; exp_stall_prev = 1'b0;
        rst = 1'b1; pipe_write_en = 1'b0;
        cycle();
        chk("arst_release_ready", last_ready, 1);
        chk("arst_release_en", last_en, 0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
